// File: rtl/snoop_bus_controller_if.sv
// ============================================================================
// Module : snoop_bus_pkg / snoop_bus_controller_if
// Brief  : RAM status type and the cache/RAM bundle of the snoop controller.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package snoop_bus_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

interface snoop_bus_controller_if
    import snoop_bus_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic [NCORES-1:0]             dREN;
    logic [NCORES-1:0]             dWEN;
    logic [NCORES-1:0][ADDR_W-1:0] daddr;
    logic [NCORES-1:0][WORD_W-1:0] dstore;
    logic [NCORES-1:0]             cctrans;
    logic [NCORES-1:0]             ccwrite;
    logic [NCORES-1:0]             dwait;
    logic [NCORES-1:0][WORD_W-1:0] dload;
    logic [NCORES-1:0]             ccwait;
    logic [NCORES-1:0]             ccinv;
    logic [NCORES-1:0][ADDR_W-1:0] ccsnoopaddr;
    logic                          ramREN;
    logic                          ramWEN;
    logic [ADDR_W-1:0]             ramaddr;
    logic [WORD_W-1:0]             ramstore;
    logic [WORD_W-1:0]             ramload;
    ramstate_t                     ramstate;

    // Controller side
    modport slave (
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    // Caches + RAM side
    modport master (
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

`default_nettype wire

// File: rtl/snoop_bus_controller.sv
// ============================================================================
// Module : snoop_bus_controller
// Brief  : Round-robin N-core snooping coherence controller in front of one RAM.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module snoop_bus_controller
    import snoop_bus_pkg::*;
#(
    parameter int NCORES    = 2,
    parameter int ADDR_W    = 32,
    parameter int WORD_W    = 32,
    parameter int SNOOP_LAT = 1
)(
    input  wire logic             CLK,
    input  wire logic             nRST,
    snoop_bus_controller_if.slave bus
);
    localparam int IDX_W = $clog2(NCORES);
    localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NCORES - 1);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SNOOP_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SNOOP   = 3'd1,
        ST_WB      = 3'd2,
        ST_RD      = 3'd3,
        ST_SNOOPWB = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_req,   w_req_nxt;
    logic [IDX_W-1:0] r_last,  w_last_nxt;
    logic [IDX_W-1:0] r_snp,   w_snp_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

    logic [NCORES-1:0] w_elig;
    logic              w_any_elig;
    logic [IDX_W-1:0]  w_grant;
    logic [IDX_W-1:0]  w_rr_idx;
    logic              w_dirty;
    logic [IDX_W-1:0]  w_dirty_idx;
    logic              w_req_live;
    logic              w_access;

    assign w_elig     = bus.cctrans & (bus.dREN | bus.dWEN);
    assign w_req_live = bus.cctrans[r_req];
    assign w_access   = (bus.ramstate == ACCESS);

    // Walk downward so the last hit written is the nearest one after r_last.
    always_comb begin
        w_any_elig = 1'b0;
        w_grant    = r_last;
        w_rr_idx   = '0;
        for (int k = NCORES; k >= 1; k--) begin
            w_rr_idx = IDX_W'((int'(r_last) + k) % NCORES);
            if (w_elig[w_rr_idx]) begin
                w_any_elig = 1'b1;
                w_grant    = w_rr_idx;
            end
        end
    end

    always_comb begin
        w_dirty     = 1'b0;
        w_dirty_idx = '0;
        for (int s = NCORES - 1; s >= 0; s--) begin
            if ((IDX_W'(s) != r_req) && bus.cctrans[s] && bus.ccwrite[s]) begin
                w_dirty     = 1'b1;
                w_dirty_idx = IDX_W'(s);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_last  <= C_LAST_RST;
            r_snp   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_last  <= w_last_nxt;
            r_snp   <= w_snp_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_last_nxt  = r_last;
        w_snp_nxt   = r_snp;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_elig) begin
                    w_req_nxt   = w_grant;
                    w_last_nxt  = w_grant;
                    w_cnt_nxt   = C_CNT_LOAD;
                    w_state_nxt = bus.dWEN[w_grant] ? ST_WB : ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                if (!w_req_live) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    if (w_dirty) begin
                        w_snp_nxt   = w_dirty_idx;
                        w_state_nxt = ST_SNOOPWB;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RD, ST_WB: begin
                if (!w_req_live || w_access) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SNOOPWB: begin
                if (w_access) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes follow the state; only the completion pulse looks at ramstate.
    always_comb begin
        bus.dwait       = '1;
        bus.dload       = '0;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        case (r_state)
            ST_SNOOP: begin
                for (int s = 0; s < NCORES; s++) begin
                    if (IDX_W'(s) != r_req) begin
                        bus.ccwait[s]      = 1'b1;
                        bus.ccsnoopaddr[s] = bus.daddr[r_req];
                        bus.ccinv[s]       = bus.ccwrite[r_req];
                    end
                end
            end
            ST_RD: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.daddr[r_req];
                if (w_access && w_req_live) begin
                    bus.dload[r_req] = bus.ramload;
                    bus.dwait[r_req] = 1'b0;
                end
            end
            ST_WB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = bus.daddr[r_req];
                bus.ramstore = bus.dstore[r_req];
                if (w_access && w_req_live) begin
                    bus.dwait[r_req] = 1'b0;
                end
            end
            ST_SNOOPWB: begin
                bus.ccwait[r_snp]      = 1'b1;
                bus.ccsnoopaddr[r_snp] = bus.daddr[r_req];
                bus.ccinv[r_snp]       = bus.ccwrite[r_req];
                bus.ramWEN             = 1'b1;
                bus.ramaddr            = bus.daddr[r_req];
                bus.ramstore           = bus.dstore[r_snp];
                if (w_access) begin
                    bus.dload[r_req] = bus.dstore[r_snp];
                    bus.dwait[r_req] = 1'b0;
                    bus.dwait[r_snp] = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_snoop_bus_controller.sv
// ============================================================================
// Module : tb_snoop_bus_controller
// Brief  : Directed scoreboard bench for snoop_bus_controller with four cores.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_snoop_bus_controller;
    import snoop_bus_pkg::*;

    localparam int NCORES = 4;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    typedef struct {
        logic [3:0]  dwait;
        int          core;
        logic [31:0] data;
        logic [31:0] addr;
        bit          rd;
    } exp_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   n_total = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    snoop_bus_controller_if #(.NCORES(NCORES), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    snoop_bus_controller #(
        .NCORES(NCORES), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SNOOP_LAT(1)
    ) u_dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.dREN = '0; bus.dWEN = '0; bus.daddr = '0; bus.dstore = '0;
        bus.cctrans = '0; bus.ccwrite = '0; bus.ramload = '0; bus.ramstate = BUSY;
    endtask

    task automatic push(input logic [3:0] dw, input int core, input logic [31:0] data,
                        input logic [31:0] addr, input bit rd);
        exp_t e;
        e.dwait = dw; e.core = core; e.data = data; e.addr = addr; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic expect_done(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++; n_fail++;
            $display("FAIL %s: completion observed with empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_dwait"}, 128'(bus.dwait), 128'(e.dwait));
            chk({tag, "_ramaddr"}, 128'(bus.ramaddr), 128'(e.addr));
            if (e.rd) chk({tag, "_dload"}, 128'(bus.dload[e.core]), 128'(e.data));
            else      chk({tag, "_ramstore"}, 128'(bus.ramstore), 128'(e.data));
        end
    endtask

    task automatic wait_done(input int budget, output int ticks, output bit ok);
        ticks = 0;
        ok    = 1'b0;
        while (!ok && ticks < budget) begin
            tick(); #1;
            ticks++;
            if (bus.dwait != '1) ok = 1'b1;
        end
    endtask

    initial begin
        int  t;
        bit  ok;
        clear_inputs();

        // Reset with RAM busy and no requests
        repeat (3) tick();
        #1;
        chk("rst_dwait",  128'(bus.dwait),  128'(4'hF));
        chk("rst_ramREN", 128'(bus.ramREN), 128'(0));
        chk("rst_ramWEN", 128'(bus.ramWEN), 128'(0));
        chk("rst_ccwait", 128'(bus.ccwait), 128'(0));
        tick();
        nRST = 1'b1;

        // Clean read by core 0, three BUSY cycles then ACCESS
        tick();
        bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'hABCD;
        push(4'b1110, 0, 32'h1234, 32'hABCD, 1'b1);
        #1;
        chk("rd_idle_ccwait", 128'(bus.ccwait), 128'(0));
        tick(); #1;
        chk("rd_snoop_ccwait", 128'(bus.ccwait), 128'(4'b1110));
        chk("rd_snoop_addr1",  128'(bus.ccsnoopaddr[1]), 128'(32'hABCD));
        chk("rd_snoop_inv",    128'(bus.ccinv), 128'(0));
        tick(); #1;
        chk("rd_busy1_ren",    128'(bus.ramREN), 128'(1));
        chk("rd_busy1_ccwait", 128'(bus.ccwait), 128'(0));
        chk("rd_busy1_dwait",  128'(bus.dwait),  128'(4'hF));
        tick(); #1;
        chk("rd_busy2_ren", 128'(bus.ramREN), 128'(1));
        tick(); #1;
        chk("rd_busy3_ren", 128'(bus.ramREN), 128'(1));
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h1234;
        #1;
        expect_done("rd_done");
        tick();
        clear_inputs();
        #1;
        chk("rd_after_dwait", 128'(bus.dwait),  128'(4'hF));
        chk("rd_after_ren",   128'(bus.ramREN), 128'(0));

        // Read-for-ownership by core 0, core 1 holds it Modified
        tick();
        bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1; bus.daddr[0] = 32'h100;
        bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.dstore[1] = 32'hBEEF;
        push(4'b1100, 0, 32'hBEEF, 32'h100, 1'b1);
        tick(); #1;
        chk("rfo_snoop_ccinv",  128'(bus.ccinv),  128'(4'b1110));
        chk("rfo_snoop_ccwait", 128'(bus.ccwait), 128'(4'b1110));
        tick(); #1;
        chk("rfo_swb_wen",    128'(bus.ramWEN),   128'(1));
        chk("rfo_swb_ren",    128'(bus.ramREN),   128'(0));
        chk("rfo_swb_store",  128'(bus.ramstore), 128'(32'hBEEF));
        chk("rfo_swb_ccwait", 128'(bus.ccwait),   128'(4'b0010));
        tick();
        bus.ramstate = ACCESS;
        #1;
        expect_done("rfo_done");
        tick();
        clear_inputs();
        #1;
        chk("rfo_after_dwait", 128'(bus.dwait), 128'(4'hF));

        // Core 1 read aborted by dropping cctrans during RD
        tick();
        bus.dREN[1] = 1'b1; bus.cctrans[1] = 1'b1; bus.daddr[1] = 32'h200;
        tick(); #1;
        chk("ab_snoop_ccwait", 128'(bus.ccwait), 128'(4'b1101));
        tick(); #1;
        chk("ab_rd_ren",  128'(bus.ramREN),  128'(1));
        chk("ab_rd_addr", 128'(bus.ramaddr), 128'(32'h200));
        tick();
        bus.cctrans[1] = 1'b0;
        #1;
        chk("ab_drop_dwait", 128'(bus.dwait), 128'(4'hF));
        tick(); #1;
        chk("ab_idle_ren",   128'(bus.ramREN), 128'(0));
        chk("ab_idle_dwait", 128'(bus.dwait),  128'(4'hF));
        clear_inputs();

        // Reset asserted in the middle of a cache-to-cache transfer
        tick();
        bus.dREN[2] = 1'b1; bus.cctrans[2] = 1'b1; bus.daddr[2] = 32'h300;
        bus.cctrans[3] = 1'b1; bus.ccwrite[3] = 1'b1; bus.dstore[3] = 32'hCAFE;
        tick(); #1;
        chk("mr_snoop_ccwait", 128'(bus.ccwait), 128'(4'b1011));
        tick(); #1;
        chk("mr_swb_wen",   128'(bus.ramWEN),   128'(1));
        chk("mr_swb_store", 128'(bus.ramstore), 128'(32'hCAFE));
        nRST = 1'b0;
        #1;
        chk("mr_wen",      128'(bus.ramWEN),      128'(0));
        chk("mr_ccwait",   128'(bus.ccwait),      128'(0));
        chk("mr_dwait",    128'(bus.dwait),       128'(4'hF));
        chk("mr_ramaddr",  128'(bus.ramaddr),     128'(0));
        chk("mr_ramstore", 128'(bus.ramstore),    128'(0));
        chk("mr_snpaddr",  128'(bus.ccsnoopaddr), 128'(0));
        clear_inputs();
        tick();
        nRST = 1'b1;

        // All cores write back continuously, RAM always ready
        tick();
        for (int i = 0; i < NCORES; i++) begin
            bus.dWEN[i]    = 1'b1;
            bus.cctrans[i] = 1'b1;
            bus.daddr[i]   = 32'h1000 + 32'(i);
            bus.dstore[i]  = 32'hD0 + 32'(i);
        end
        bus.ramstate = ACCESS;
        for (int g = 0; g < 5; g++) begin
            int c;
            c = g % NCORES;
            push(~(4'b0001 << c), c, 32'hD0 + 32'(c), 32'h1000 + 32'(c), 1'b0);
        end
        for (int g = 0; g < 5; g++) begin
            wait_done(6, t, ok);
            if (!ok) begin
                n_total++; n_fail++;
                $display("FAIL rr_timeout_%0d: no completion within 6 cycles", g);
            end else begin
                expect_done($sformatf("rr_grant%0d", g));
                chk($sformatf("rr_latency%0d", g), 128'(t), 128'((g == 0) ? 1 : 2));
            end
        end
        tick();
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

`default_nettype wire
